// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential execute stage feeding register-file write-back
//
// Purpose: takes two operands from the register file, performs one of eight
// operations (single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR, or an iterative
// shift-add MUL), then presents a one-cycle write-back (result/dir_wr/wr_en).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, sampled only while idle
//   op               000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 SHL 110 SHR 111 MUL
//   a_in, b_in       operands (register file DOA / DOB)
//   dst_in           destination register address
//   busy             high whenever not idle
//   done, wr_en      one-cycle pulse during write-back
//   result, dir_wr   write-back data/address, held after write-back
//   zero, carry      flags of the last completed operation
module alu_seq #(
  parameter int W      = 8,
  parameter int MUL_IT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [1:0]   dst_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [1:0]   dir_wr,
  output logic         wr_en,
  output logic         zero,
  output logic         carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int CW = (MUL_IT > 1) ? $clog2(MUL_IT) : 1;
  localparam logic [CW-1:0] LAST_IT = CW'(MUL_IT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t state, state_next;

  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     dst_q;
  logic [2*W-1:0] acc, mcand, acc_next;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   alu_res;
  logic           alu_c;
  logic [W:0]     sum_ext, diff_ext, shl_ext, shr_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (op == OP_MUL) ? MUL : EXEC;
      end
      EXEC: state_next = WB;
      MUL:  if (cnt == LAST_IT) state_next = WB;
      WB: begin
        done       = 1'b1;
        wr_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shifts are done on a W+1 wide vector so the bit shifted out lands in the
  // extra position; a shift of zero leaves that position clear.
  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    shl_ext  = {1'b0, a_q} << b_q[2:0];
    shr_ext  = {a_q, 1'b0} >> b_q[2:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum_ext[W-1:0];  alu_c = sum_ext[W];  end
      OP_SUB: begin alu_res = diff_ext[W-1:0]; alu_c = diff_ext[W]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin alu_res = shl_ext[W-1:0]; alu_c = shl_ext[W]; end
      OP_SHR: begin alu_res = shr_ext[W:1];   alu_c = shr_ext[0]; end
      default: ;
    endcase
  end

  // LSB-first shift-add: multiplicand walks left, multiplier walks right.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dst_q  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      dir_wr <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          a_q    <= a_in;
          b_q    <= b_in;
          dst_q  <= dst_in;
          acc    <= '0;
          mcand  <= {{W{1'b0}}, a_in};
          mplier <= b_in;
          cnt    <= '0;
        end
        EXEC: begin
          result <= alu_res;
          carry  <= alu_c;
          zero   <= (alu_res == '0);
          dir_wr <= dst_q;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_IT) begin
            result <= acc_next[W-1:0];
            carry  <= |acc_next[2*W-1:W];
            zero   <= (acc_next[W-1:0] == '0);
            dir_wr <= dst_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] a_in, b_in;
  logic [1:0] dst_in;
  logic       busy, done, wr_en, zero, carry;
  logic [7:0] result;
  logic [1:0] dir_wr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(8), .MUL_IT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .dst_in(dst_in),
    .busy(busy), .done(done), .result(result), .dir_wr(dir_wr),
    .wr_en(wr_en), .zero(zero), .carry(carry)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, result} from plain integer arithmetic.
  function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned x, y, r, c, s;
    x = a; y = b; s = b % 8; r = 0; c = 0;
    case (o)
      3'd0: begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
      3'd1: begin r = (x + 256 - y) % 256; c = (x < y) ? 1 : 0; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin r = (x << s) % 256; c = (s == 0) ? 0 : (x >> (8 - s)) & 1; end
      3'd6: begin r = x >> s;         c = (s == 0) ? 0 : (x >> (s - 1)) & 1; end
      default: begin r = (x * y) % 256; c = (x * y > 255) ? 1 : 0; end
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [1:0] d);
    logic [8:0] exp;
    int k, lat;
    exp = model(o, a, b);
    lat = (o == 3'b111) ? 8 : 1;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; dst_in = d;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    k = 0;
    while (!wr_en && k < 20) begin
      // Scramble inputs and pulse start mid-operation; none of it may matter.
      start  = (k == 3);
      op     = 3'b000;
      a_in   = 8'($urandom);
      b_in   = 8'($urandom);
      dst_in = 2'($urandom);
      @(negedge clk);
      k++;
    end
    // start during write-back must be ignored as well.
    start = 1'b1;
    op = 3'($urandom);
    check("latency", k, lat);
    check("done", done, 1);
    check("busy_wb", busy, 1);
    check("result", result, exp[7:0]);
    check("carry", carry, exp[8]);
    check("zero", zero, exp[7:0] == 8'h00);
    check("dir_wr", dir_wr, d);
    @(negedge clk);
    start = 1'b0;
    check("wr_en_single", wr_en, 0);
    check("busy_idle", busy, 0);
    check("result_held", result, exp[7:0]);
    check("dir_wr_held", dir_wr, d);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0; dst_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, carry}, 0);
    check("rst_dir_wr", dir_wr, 0);
    rst_n = 1'b1;

    run_op(3'b000, 8'hF0, 8'h20, 2'd2);
    run_op(3'b001, 8'h05, 8'h05, 2'd1);
    run_op(3'b001, 8'h03, 8'h05, 2'd3);
    run_op(3'b111, 8'h0F, 8'h11, 2'd0);
    run_op(3'b111, 8'h10, 8'h10, 2'd2);
    run_op(3'b101, 8'h81, 8'h01, 2'd1);
    run_op(3'b110, 8'h81, 8'h00, 2'd3);

    // Reset during MUL iteration 4 aborts the op with no write-back.
    run_op(3'b000, 8'h12, 8'h34, 2'd3);
    @(negedge clk);
    start = 1'b1; op = 3'b111; a_in = 8'h0F; b_in = 8'h11; dst_in = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_dir_wr", dir_wr, 0);
    check("abort_flags", {zero, carry}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_wr", wr_en, 0);
    end
    rst_n = 1'b1;
    run_op(3'b000, 8'h01, 8'h01, 2'd2);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
